norm_shift_stage: RTL

//  Normalisation stage after leading-zero anticipation. Takes the unnormalised FMA sum

---
 rtl/norm_shift_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/norm_shift_stage.sv
// Two-stage post-LZA normaliser: coarse (x8) left shift in S1, fine shift plus one-bit
// leading-one correction in S2, for one 56-bit lane or packed 32b/24b lanes.
module norm_shift_stage #(
   parameter int unsigned EXPW = 13
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      cont,
   input  logic [55:0]     sum,
   input  logic [1:0]      V,
   input  logic [9:0]      P,
   input  logic [EXPW-1:0] exp_hi,
   input  logic [EXPW-1:0] exp_lo,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      cont_out,
   output logic [55:0]     norm,
   output logic [EXPW-1:0] exp_out_hi,
   output logic [EXPW-1:0] exp_out_lo,
   output logic            zero_hi,
   output logic            zero_lo
);

   logic s2_load, s1_load;

   // S1 state
   logic            s1_valid_q;
   logic [2:0]      s1_cont_q;
   logic [55:0]     s1_x_q, s1_x_d;
   logic [2:0]      s1_fhi_q, s1_fhi_d;
   logic [2:0]      s1_flo_q, s1_flo_d;
   logic            s1_zhi_q, s1_zhi_d;
   logic            s1_zlo_q, s1_zlo_d;
   logic [EXPW-1:0] s1_ehi_q, s1_ehi_d;
   logic [EXPW-1:0] s1_elo_q, s1_elo_d;

   // S2 (output) state
   logic            out_valid_q;
   logic [2:0]      cont_out_q;
   logic [55:0]     norm_q, norm_d;
   logic [EXPW-1:0] ehi_q, ehi_d;
   logic [EXPW-1:0] elo_q, elo_d;
   logic            zhi_q, zhi_d;
   logic            zlo_q, zlo_d;

   logic [5:0] k_s;
   logic [4:0] k_h, k_l;
   logic       mode_single, mode_dual;
   logic       s2_single, s2_dual;

   assign k_s = P[5:0];
   assign k_h = P[9:5];
   assign k_l = P[4:0];
   assign mode_single = (cont == 3'b000) || (cont == 3'b010);
   assign mode_dual   = (cont == 3'b001);

   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   // Coarse stage; exponents take the full LZA count here, correction is removed in S2.
   always_comb begin
      s1_x_d   = '0;
      s1_fhi_d = '0;
      s1_flo_d = '0;
      s1_zhi_d = 1'b0;
      s1_zlo_d = 1'b0;
      s1_ehi_d = '0;
      s1_elo_d = '0;
      if (mode_single) begin
         s1_zhi_d = !V[0] || (sum == '0) || (k_s > 6'd55);
         s1_x_d   = sum << {k_s[5:3], 3'b000};
         s1_fhi_d = k_s[2:0];
         s1_ehi_d = exp_hi - EXPW'(k_s);
      end else if (mode_dual) begin
         s1_zhi_d        = !V[1] || (sum[55:24] == '0);
         s1_zlo_d        = !V[0] || (sum[23:0] == '0) || (k_l > 5'd23);
         s1_x_d[55:24]   = sum[55:24] << {k_h[4:3], 3'b000};
         s1_x_d[23:0]    = sum[23:0] << {k_l[4:3], 3'b000};
         s1_fhi_d        = k_h[2:0];
         s1_flo_d        = k_l[2:0];
         s1_ehi_d        = exp_hi - EXPW'(k_h);
         s1_elo_d        = exp_lo - EXPW'(k_l);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_cont_q  <= '0;
         s1_x_q     <= '0;
         s1_fhi_q   <= '0;
         s1_flo_q   <= '0;
         s1_zhi_q   <= 1'b0;
         s1_zlo_q   <= 1'b0;
         s1_ehi_q   <= '0;
         s1_elo_q   <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_cont_q <= cont;
            s1_x_q    <= s1_x_d;
            s1_fhi_q  <= s1_fhi_d;
            s1_flo_q  <= s1_flo_d;
            s1_zhi_q  <= s1_zhi_d;
            s1_zlo_q  <= s1_zlo_d;
            s1_ehi_q  <= s1_ehi_d;
            s1_elo_q  <= s1_elo_d;
         end
      end
   end

   // Fine stage: shift by 0..7, then one extra shift if the top bit is still clear.
   logic [55:0] y_s, y_s2;
   logic [31:0] y_h, y_h2;
   logic [23:0] y_l, y_l2;
   logic        c_s, c_h, c_l;

   assign s2_single = (s1_cont_q == 3'b000) || (s1_cont_q == 3'b010);
   assign s2_dual   = (s1_cont_q == 3'b001);

   always_comb begin
      y_s  = s1_x_q << s1_fhi_q;
      c_s  = !y_s[55];
      y_s2 = c_s ? (y_s << 1) : y_s;
      y_h  = s1_x_q[55:24] << s1_fhi_q;
      c_h  = !y_h[31];
      y_h2 = c_h ? (y_h << 1) : y_h;
      y_l  = s1_x_q[23:0] << s1_flo_q;
      c_l  = !y_l[23];
      y_l2 = c_l ? (y_l << 1) : y_l;

      norm_d = '0;
      ehi_d  = '0;
      elo_d  = '0;
      zhi_d  = 1'b0;
      zlo_d  = 1'b0;
      if (s2_single) begin
         zhi_d = s1_zhi_q || (y_s2 == '0);
         if (!zhi_d) begin
            norm_d = y_s2;
            ehi_d  = s1_ehi_q - EXPW'(c_s);
         end
      end else if (s2_dual) begin
         zhi_d = s1_zhi_q || (y_h2 == '0);
         zlo_d = s1_zlo_q || (y_l2 == '0);
         if (!zhi_d) begin
            norm_d[55:24] = y_h2;
            ehi_d         = s1_ehi_q - EXPW'(c_h);
         end
         if (!zlo_d) begin
            norm_d[23:0] = y_l2;
            elo_d        = s1_elo_q - EXPW'(c_l);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         cont_out_q  <= '0;
         norm_q      <= '0;
         ehi_q       <= '0;
         elo_q       <= '0;
         zhi_q       <= 1'b0;
         zlo_q       <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            cont_out_q <= s1_cont_q;
            norm_q     <= norm_d;
            ehi_q      <= ehi_d;
            elo_q      <= elo_d;
            zhi_q      <= zhi_d;
            zlo_q      <= zlo_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign cont_out   = cont_out_q;
   assign norm       = norm_q;
   assign exp_out_hi = ehi_q;
   assign exp_out_lo = elo_q;
   assign zero_hi    = zhi_q;
   assign zero_lo    = zlo_q;

endmodule
